// File: rtl/fetch_pkg.sv
// Shared types for the fetch front end: FSM states and the F1 pipeline entry.
// Imported by the fetch sequencer and its hold buffer.
package fetch_pkg;

    localparam int DEF_PC_W    = 32;
    localparam int DEF_INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STALL,
        HALT
    } fetch_state_t;

    typedef struct packed {
        logic                valid;
        logic [DEF_PC_W-1:0] pc;
        logic                pred;
    } f1_entry_t;

endpackage

// File: rtl/fetch_hold_reg.sv
// One-entry hold buffer: keeps the word under a decode stall while memory
// re-reads the frozen fetch PC, and muxes it ahead of the live read data.
module fetch_hold_reg
    import fetch_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               capture,
    input  logic               drain,
    input  logic [INSTR_W-1:0] rdata,
    output logic               hold_vld,
    output logic [INSTR_W-1:0] instr
);

    logic [INSTR_W-1:0] hold_instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld   <= 1'b0;
            hold_instr <= '0;
        end else if (flush || (hold_vld && drain)) begin
            hold_vld   <= 1'b0;
        end else if (capture) begin
            hold_vld   <= 1'b1;
            hold_instr <= rdata;
        end
    end

    assign instr = hold_vld ? hold_instr : rdata;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: picks the next word index (redirect, stall-hold, predicted
// target, PC+1) and hands fetched words to decode over valid/ready.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              PC_W       = DEF_PC_W,
    parameter int              INSTR_W    = DEF_INSTR_W,
    parameter int              IMEM_DEPTH = 33,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               bp_taken,
    input  logic [PC_W-1:0]    bp_target,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic               out_pred_taken,
    output logic               halt
);

    localparam logic [PC_W-1:0] DEPTH = PC_W'(IMEM_DEPTH);

    fetch_state_t       state;
    f1_entry_t          f1;
    logic [PC_W-1:0]    fpc;
    logic [PC_W-1:0]    nxt;
    logic               issue;
    logic               nxt_ok;
    logic               redir_ok;
    logic               advance;
    logic               hold_vld;
    logic [INSTR_W-1:0] word;

    assign nxt      = bp_taken ? bp_target : fpc + PC_W'(1);
    assign issue    = fpc < DEPTH;
    assign nxt_ok   = nxt < DEPTH;
    assign redir_ok = redirect_pc < DEPTH;
    assign advance  = !f1.valid || out_ready;

    // fpc is only ever loaded with in-range indices, so a halted
    // sequencer keeps re-reading the last word it issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            fpc   <= RESET_PC;
            f1    <= '0;
        end else if (redirect_valid) begin
            f1.valid <= 1'b0;
            if (redir_ok) begin
                fpc   <= redirect_pc;
                state <= RUN;
            end else begin
                state <= HALT;
            end
        end else if (!advance) begin
            if (state != HALT) begin
                state <= STALL;
            end
        end else if (state == HALT) begin
            f1.valid <= 1'b0;
        end else begin
            f1 <= '{valid: issue, pc: fpc, pred: bp_taken};
            if (issue && nxt_ok) begin
                fpc   <= nxt;
                state <= RUN;
            end else begin
                state <= HALT;
            end
        end
    end

    fetch_hold_reg #(
        .INSTR_W (INSTR_W)
    ) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .capture  (f1.valid && !out_ready && !hold_vld),
        .drain    (out_ready),
        .rdata    (imem_rdata),
        .hold_vld (hold_vld),
        .instr    (word)
    );

    assign imem_addr      = fpc;
    assign out_valid      = f1.valid;
    assign out_pc         = f1.pc;
    assign out_pred_taken = f1.valid && f1.pred;
    assign out_instr      = f1.valid ? word : '0;
    assign halt           = (state == HALT) && !f1.valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: the expected delivery stream is the PC walk
// implied by the predictor table, restarted at every redirect or reset.
module tb_fetch_ctrl;

    localparam logic [31:0] DEPTH = 32'd33;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        bp_taken;
    logic [31:0] bp_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_pred_taken;
    logic        halt;

    logic [31:0] mem   [64];
    logic        bp_tk [64];
    logic [31:0] bp_tg [64];

    exp_t exp_q[$];
    exp_t pend_q[$];
    logic pend_flush = 1'b0;
    logic pend_end   = 1'b0;
    logic exp_end    = 1'b0;

    int checks   = 0;
    int failures = 0;

    fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .bp_taken       (bp_taken),
        .bp_target      (bp_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pred_taken (out_pred_taken),
        .halt           (halt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= mem[imem_addr[5:0]];

    assign bp_taken  = bp_tk[imem_addr[5:0]];
    assign bp_target = bp_tg[imem_addr[5:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic set_tables(input int mode);
        for (int i = 0; i < 64; i++) begin
            bp_tk[i] = 1'b0;
            bp_tg[i] = 32'd0;
        end
        if (mode == 1) begin
            bp_tk[3] = 1'b1;
            bp_tg[3] = 32'd10;
        end
        if (mode == 2) begin
            for (int i = 0; i < 33; i++) begin
                if ($urandom_range(5) == 0) begin
                    bp_tk[i] = 1'b1;
                    bp_tg[i] = 32'($urandom_range(40));
                end
            end
        end
    endtask

    // Words decode must see: follow taken/target or +1 until out of range.
    task automatic build_walk(input logic [31:0] start);
        logic [31:0] pc;
        int n;
        exp_t e;
        pend_q.delete();
        pc = start;
        n  = 0;
        while (pc < DEPTH && n < 300) begin
            e.pc    = pc;
            e.instr = mem[pc[5:0]];
            e.pred  = bp_tk[pc[5:0]];
            pend_q.push_back(e);
            pc = bp_tk[pc[5:0]] ? bp_tg[pc[5:0]] : pc + 32'd1;
            n++;
        end
        pend_end   = (n < 300);
        pend_flush = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] pc, input int mode);
        set_tables(mode);
        if (pc < DEPTH) begin
            build_walk(pc);
        end else begin
            pend_q.delete();
            pend_end   = 1'b1;
            pend_flush = 1'b1;
        end
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_addr",  imem_addr, 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_pc",    out_pc, 32'd0);
        chk("rst_pred",  32'(out_pred_taken), 32'd0);
        chk("rst_halt",  32'(halt), 32'd0);
    endtask

    task automatic do_reset(input int mode);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        set_tables(mode);
        build_walk(32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pend_flush) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    logic        prev_stall = 1'b0;
    logic        prev_redir = 1'b0;
    logic        prev_ok    = 1'b0;
    logic        chk_lat    = 1'b0;
    logic [31:0] stall_pc;
    logic [31:0] stall_instr;
    int          idle_cnt   = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_redir = 1'b0;
            chk_lat    = 1'b0;
            idle_cnt   = 0;
        end else begin
            if (chk_lat) chk("redir_lat", 32'(out_valid), 32'd1);
            chk_lat = prev_redir && prev_ok && !redirect_valid;
            if (prev_redir) begin
                chk("bubble", 32'(out_valid), 32'd0);
                chk("redir_halt", 32'(halt), 32'(!prev_ok));
            end else if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_pc", out_pc, stall_pc);
                chk("stall_instr", out_instr, stall_instr);
            end
            if (out_valid && out_ready) begin
                chk("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("pc", out_pc, e.pc);
                    chk("instr", out_instr, e.instr);
                    chk("pred", 32'(out_pred_taken), 32'(e.pred));
                end
            end
            prev_stall  = out_valid && !out_ready && !redirect_valid;
            stall_pc    = out_pc;
            stall_instr = out_instr;
            prev_redir  = redirect_valid;
            prev_ok     = redirect_pc < DEPTH;
            if (exp_q.size() == 0 && !pend_flush && exp_end && !redirect_valid)
                idle_cnt++;
            else
                idle_cnt = 0;
            if (idle_cnt == 3) begin
                chk("halt_flag", 32'(halt), 32'd1);
                chk("halt_valid", 32'(out_valid), 32'd0);
            end
        end
        if (pend_flush) begin
            exp_q      = pend_q;
            exp_end    = pend_end;
            pend_flush = 1'b0;
            idle_cnt   = 0;
        end
    end

    initial begin
        int n;
        int since;
        for (int i = 0; i < 64; i++) mem[i] = $urandom();
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        set_tables(0);
        build_walk(32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        out_ready = 1'b1;
        rst_n     = 1'b1;
        chk("idle_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_pc", out_pc, 32'd0);

        n = 0;
        while (!(out_valid && out_pc == 32'd5) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_pc5", out_pc, 32'd5);
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain(100);
        repeat (3) @(posedge clk);
        #1;
        chk("end_halt", 32'(halt), 32'd1);
        chk("end_valid", 32'(out_valid), 32'd0);

        redirect(32'd0, 1);
        chk("halt_clr", 32'(halt), 32'd0);
        chk("bubble0", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("redir0_valid", 32'(out_valid), 32'd1);
        chk("redir0_pc", out_pc, 32'd0);
        wait_drain(100);

        redirect(32'd5, 0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        redirect(32'd20, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("redir20_pc", out_pc, 32'd20);
        wait_drain(100);

        redirect(32'd0, 0);
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset(0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rst_restart_pc", out_pc, 32'd0);
        wait_drain(100);

        since = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            out_ready = ($urandom_range(9) < 7);
            if ($urandom_range(399) == 0) begin
                do_reset(2);
                since = 0;
            end else if (since > 40 || $urandom_range(29) == 0) begin
                redirect(32'($urandom_range(40)), 2);
                since = 0;
            end else begin
                @(posedge clk); #1;
                since++;
            end
        end

        out_ready = 1'b1;
        redirect(32'd25, 0);
        wait_drain(100);
        repeat (4) @(posedge clk);
        #1;
        chk("final_halt", 32'(halt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
